// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and defaults for the stopwatch control block.
package stopwatch_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    LAP_RUN = 3'd2,
    PAUSE   = 3'd3,
    DONE    = 3'd4
  } state_t;

  // 100 MHz clock -> one count tick every 10 ms
  localparam int TICK_DIV_DEFAULT = 1000000;

endpackage

// File: rtl/stopwatch_ctrl_if.sv
// Button inputs and counter-chain controls between debouncers, controller and digit chain.
interface stopwatch_ctrl_if;
  logic btn_ss;
  logic btn_lr;
  logic mode_down;
  logic all_zero;
  logic cnt_en;
  logic cnt_clr;
  logic cnt_dir;
  logic lap_press;
  logic lap_hold;
  logic running;
  logic done;

  modport master (
    output btn_ss, btn_lr, mode_down, all_zero,
    input  cnt_en, cnt_clr, cnt_dir, lap_press, lap_hold, running, done
  );

  modport slave (
    input  btn_ss, btn_lr, mode_down, all_zero,
    output cnt_en, cnt_clr, cnt_dir, lap_press, lap_hold, running, done
  );
endinterface

// File: rtl/stopwatch_ctrl_tick_prescaler.sv
// Free-running divide-by-TICK_DIV counter that pauses in place when run is low.
module stopwatch_ctrl_tick_prescaler
  import stopwatch_ctrl_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic run,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count_reg;

  assign tick = (count_reg == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count_reg <= '0;
    end else if (run) begin
      count_reg <= tick ? '0 : count_reg + ONE;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: turns button pulses into enable/clear/direction/lap strobes
// for the digit chain, and halts a count-down run at zero.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  stopwatch_ctrl_if.slave  sw
);

  state_t state_reg;
  logic   dir_reg;
  logic   clr_reg;
  logic   lap_press_reg;
  logic   lap_hold_reg;
  logic   running_reg;
  logic   done_reg;

  logic   tick;
  logic   at_floor;
  logic   clr_req;

  // Counting down with every digit at zero: any further enable would wrap the chain
  assign at_floor = ~dir_reg & sw.all_zero;

  always_comb begin
    clr_req = 1'b0;
    case (state_reg)
      IDLE, PAUSE: clr_req = ~sw.btn_ss & sw.btn_lr;
      DONE:        clr_req = sw.btn_ss | sw.btn_lr;
      default:     clr_req = 1'b0;
    endcase
  end

  stopwatch_ctrl_tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_req),
    .run  (running_reg),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      dir_reg       <= 1'b1;
      clr_reg       <= 1'b1;
      lap_press_reg <= 1'b0;
      lap_hold_reg  <= 1'b0;
      running_reg   <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      clr_reg       <= clr_req;
      lap_press_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          dir_reg <= ~sw.mode_down;
          // Refuse to start a count-down that is already at zero
          if (sw.btn_ss && !(sw.mode_down && sw.all_zero)) begin
            state_reg   <= RUN;
            running_reg <= 1'b1;
          end
        end
        RUN: begin
          if (at_floor) begin
            state_reg    <= DONE;
            running_reg  <= 1'b0;
            done_reg     <= 1'b1;
            lap_hold_reg <= 1'b0;
          end else if (sw.btn_ss) begin
            state_reg   <= PAUSE;
            running_reg <= 1'b0;
          end else if (sw.btn_lr) begin
            state_reg     <= LAP_RUN;
            lap_press_reg <= 1'b1;
            lap_hold_reg  <= 1'b1;
          end
        end
        LAP_RUN: begin
          if (at_floor) begin
            state_reg    <= DONE;
            running_reg  <= 1'b0;
            done_reg     <= 1'b1;
            lap_hold_reg <= 1'b0;
          end else if (sw.btn_ss) begin
            state_reg    <= PAUSE;
            running_reg  <= 1'b0;
            lap_hold_reg <= 1'b0;
          end else if (sw.btn_lr) begin
            state_reg    <= RUN;
            lap_hold_reg <= 1'b0;
          end
        end
        PAUSE: begin
          if (sw.btn_ss) begin
            state_reg   <= RUN;
            running_reg <= 1'b1;
          end else if (sw.btn_lr) begin
            state_reg <= IDLE;
          end
        end
        DONE: begin
          if (sw.btn_ss || sw.btn_lr) begin
            state_reg <= IDLE;
            done_reg  <= 1'b0;
          end
        end
        default: begin
          state_reg    <= IDLE;
          running_reg  <= 1'b0;
          done_reg     <= 1'b0;
          lap_hold_reg <= 1'b0;
        end
      endcase
    end
  end

  assign sw.cnt_en    = tick & running_reg & ~at_floor;
  assign sw.cnt_clr   = clr_reg;
  assign sw.cnt_dir   = dir_reg;
  assign sw.lap_press = lap_press_reg;
  assign sw.lap_hold  = lap_hold_reg;
  assign sw.running   = running_reg;
  assign sw.done      = done_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed and randomized check of stopwatch_ctrl against a flag-and-elapsed-time model.
module tb_stopwatch_ctrl;

  localparam int TD = 4;

  logic clk;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  stopwatch_ctrl_if sw();

  stopwatch_ctrl #(.TICK_DIV(TD)) dut (
    .clk (clk),
    .rst (rst),
    .sw  (sw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: counting/paused/finished flags plus cycles counted since last clear
  bit m_valid = 0;
  bit m_active, m_paused, m_done, m_lap, m_dir, m_clr, m_press;
  int m_elapsed;

  always @(posedge clk) begin
    bit idle, floor_hit;
    if (rst) begin
      m_valid = 1; m_active = 0; m_paused = 0; m_done = 0; m_lap = 0;
      m_dir = 1; m_clr = 1; m_press = 0; m_elapsed = 0;
    end else if (m_valid) begin
      idle      = !m_active && !m_paused && !m_done;
      floor_hit = !m_dir && sw.all_zero;
      m_clr = 0;
      m_press = 0;
      if (m_active) m_elapsed++;
      if (idle) begin
        m_dir = !sw.mode_down;
        if (sw.btn_ss) begin
          if (!(sw.mode_down && sw.all_zero)) m_active = 1;
        end else if (sw.btn_lr) begin
          m_clr = 1; m_elapsed = 0;
        end
      end else if (m_active) begin
        if (floor_hit) begin
          m_active = 0; m_done = 1; m_lap = 0;
        end else if (sw.btn_ss) begin
          m_active = 0; m_paused = 1; m_lap = 0;
        end else if (sw.btn_lr) begin
          if (m_lap) m_lap = 0;
          else begin m_lap = 1; m_press = 1; end
        end
      end else if (m_paused) begin
        if (sw.btn_ss) begin
          m_paused = 0; m_active = 1;
        end else if (sw.btn_lr) begin
          m_paused = 0; m_clr = 1; m_elapsed = 0;
        end
      end else if (sw.btn_ss || sw.btn_lr) begin
        m_done = 0; m_clr = 1; m_elapsed = 0;
      end
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cnt_en", sw.cnt_en,
          m_active && (m_elapsed % TD == TD - 1) && !(!m_dir && sw.all_zero));
      chk("cnt_clr",   sw.cnt_clr,   m_clr);
      chk("cnt_dir",   sw.cnt_dir,   m_dir);
      chk("lap_press", sw.lap_press, m_press);
      chk("lap_hold",  sw.lap_hold,  m_lap);
      chk("running",   sw.running,   m_active);
      chk("done",      sw.done,      m_done);
    end
  end

  // Apply inputs, let one rising edge sample them, return just after the edge
  task automatic drive(input logic r, input logic ss, input logic lr,
                       input logic md, input logic az);
    rst = r; sw.btn_ss = ss; sw.btn_lr = lr; sw.mode_down = md; sw.all_zero = az;
    @(posedge clk);
    #2;
    $display("[TB] rst=%b ss=%b lr=%b md=%b az=%b -> en=%b clr=%b dir=%b lp=%b lh=%b run=%b done=%b",
             r, ss, lr, md, az, sw.cnt_en, sw.cnt_clr, sw.cnt_dir, sw.lap_press,
             sw.lap_hold, sw.running, sw.done);
  endtask

  initial begin
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    chk("pin_reset_clr", sw.cnt_clr, 1'b1);
    chk("pin_reset_dir", sw.cnt_dir, 1'b1);
    chk("pin_reset_run", sw.running, 1'b0);
    chk("pin_reset_en",  sw.cnt_en,  1'b0);
    drive(0, 0, 0, 0, 0);
    chk("pin_clr_drop", sw.cnt_clr, 1'b0);

    // Start counting up: first enable in the 4th cycle after the press
    drive(0, 1, 0, 0, 0);
    chk("pin_start_run", sw.running, 1'b1);
    chk("pin_start_en0", sw.cnt_en, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      drive(0, 0, 0, 0, 0);
      chk("pin_first_tick", sw.cnt_en, (k == 3));
    end

    // Lap capture and release
    drive(0, 0, 1, 0, 0);
    chk("pin_lap_press", sw.lap_press, 1'b1);
    chk("pin_lap_hold",  sw.lap_hold,  1'b1);
    drive(0, 0, 0, 0, 0);
    chk("pin_lap_press_end", sw.lap_press, 1'b0);
    drive(0, 0, 1, 0, 0);
    chk("pin_lap_release", sw.lap_hold, 1'b0);
    chk("pin_lap_nopress", sw.lap_press, 1'b0);

    // Pause, then lap/reset back to idle
    drive(0, 1, 0, 0, 0);
    chk("pin_pause_run", sw.running, 1'b0);
    drive(0, 0, 1, 0, 0);
    chk("pin_idle_clr", sw.cnt_clr, 1'b1);

    // Count down until zero
    drive(0, 0, 0, 1, 0);
    chk("pin_down_dir", sw.cnt_dir, 1'b0);
    drive(0, 1, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 1);
    chk("pin_done",       sw.done,    1'b1);
    chk("pin_done_run",   sw.running, 1'b0);
    drive(0, 1, 0, 1, 1);
    chk("pin_done_clr",   sw.cnt_clr, 1'b1);
    chk("pin_done_exit",  sw.done,    1'b0);
    drive(0, 1, 0, 1, 1);
    chk("pin_zero_start", sw.running, 1'b0);

    // Simultaneous buttons, mode toggle mid-run, reset mid-run
    drive(0, 1, 0, 0, 0);
    drive(0, 1, 1, 0, 0);
    chk("pin_both_pause", sw.running,   1'b0);
    chk("pin_both_nolap", sw.lap_press, 1'b0);
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    chk("pin_dir_stable", sw.cnt_dir, 1'b1);
    drive(1, 0, 0, 1, 0);
    chk("pin_mid_rst_run", sw.running, 1'b0);
    chk("pin_mid_rst_clr", sw.cnt_clr, 1'b1);

    // Randomized phase, checked cycle by cycle against the model
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) == 0),
            (i % 400 < 200) ^ ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 6) == 0));
    end
    drive(0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Control FSM that sequences the stopwatch's chained one-digit time counters. It turns debounced start/stop and lap/reset button pulses into the counter chain's enable, clear, direction and lap-capture strobes. It contains the tick prescaler that paces counting, and it stops a count-down run at zero before the chain can wrap. It sits between the button debouncers and the counter chain / display mux.

Parameters:
TICK_DIV, 1000000, clk cycles per count tick (100 MHz -> 10 ms); legal >= 2
CW, $clog2(TICK_DIV), prescaler width (derived, not overridden)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
btn_ss  in  1  start/stop pulse, one cycle wide
btn_lr  in  1  lap/reset pulse, one cycle wide
mode_down  in  1  1 = count down, 0 = count up; sampled only in IDLE
all_zero  in  1  every digit of the counter chain reads 0
cnt_en  out  1  enable to the least-significant digit
cnt_clr  out  1  one-cycle clear to all digits
cnt_dir  out  1  1 = up, 0 = down, to all digits
lap_press  out  1  one-cycle lap-capture strobe to all digits
lap_hold  out  1  display mux selects lap value
running  out  1  state is RUN or LAP_RUN
done  out  1  count-down reached zero

Behaviour:
- States: IDLE, RUN, LAP_RUN, PAUSE, DONE. State, dir latch, prescaler, cnt_clr, lap_press and lap_hold are registered.
- Reset (rst=1 at edge):
  - state=IDLE, prescaler=0, cnt_dir=1.
  - cnt_clr=1 for the cycle after reset, then 0.
  - lap_press=0, lap_hold=0, done=0, cnt_en=0.
  - rst overrides every other input.
- Priority: btn_ss beats btn_lr when both are high in the same cycle; btn_lr is dropped.
- IDLE:
  - cnt_dir <= ~mode_down every cycle.
  - btn_ss -> RUN, except when mode_down=1 and all_zero=1 (stay IDLE).
  - btn_lr -> stay IDLE, cnt_clr pulse, prescaler=0.
- RUN:
  - btn_ss -> PAUSE.
  - btn_lr -> LAP_RUN, lap_press=1 for one cycle, lap_hold=1.
- LAP_RUN:
  - Counting continues.
  - btn_lr -> RUN, lap_hold=0, no lap_press.
  - btn_ss -> PAUSE, lap_hold=0.
- PAUSE:
  - Prescaler holds its value and is not cleared.
  - btn_ss -> RUN, resuming from the held prescaler value.
  - btn_lr -> IDLE, cnt_clr pulse, prescaler=0.
- DONE:
  - done=1.
  - btn_ss or btn_lr -> IDLE, cnt_clr pulse, prescaler=0.
- Count-down terminal: in RUN/LAP_RUN with cnt_dir=0 and all_zero=1 -> DONE next edge, lap_hold=0. Takes priority over button pulses in the same cycle.
- Prescaler:
  - Increments only in RUN/LAP_RUN.
  - tick = (prescaler == TICK_DIV-1); the prescaler wraps to 0 on tick.
- cnt_en = tick & running & ~(~cnt_dir & all_zero). This is combinational, so the chain never decrements past 0.
- Latency: btn_ss in IDLE at edge N -> running=1 after edge N; first cnt_en high in the cycle after edge N+TICK_DIV-1, i.e. exactly TICK_DIV cycles of counting per tick.
- cnt_dir is stable outside IDLE; mode_down changes during RUN/PAUSE/DONE are ignored.
- Count-up overflow of the chain is not detected here; the chain wraps.

Decomposition:
- Shared package: state encoding constants (IDLE=0, RUN=1, LAP_RUN=2, PAUSE=3, DONE=4, 3-bit) and the default TICK_DIV.
- One sub-module: tick_prescaler.
  - Parameter TICK_DIV.
  - Ports clk, rst, clr, run, tick.
  - Holds its count when run=0.

Test Plan:
- Reset, then with TICK_DIV=4 and btn_ss pulse in IDLE, mode_down=0 -> cnt_clr high one cycle after reset; running=1; cnt_en pulses every 4th cycle, first 4 cycles after the press.
- RUN, btn_lr -> lap_press high exactly 1 cycle, lap_hold=1, cnt_en keeps pulsing. Second btn_lr -> lap_hold=0, no lap_press.
- RUN, btn_ss at prescaler=2 -> PAUSE, no cnt_en. btn_ss again -> next cnt_en after 1 further count cycle. btn_lr in PAUSE -> IDLE with cnt_clr pulse.
- mode_down=1, all_zero=0, btn_ss; later drive all_zero=1 -> cnt_en forced 0 that cycle, DONE next edge, done=1. btn_ss -> IDLE with cnt_clr.
- IDLE, mode_down=1, all_zero=1, btn_ss -> stays IDLE, running=0.
- RUN, btn_ss and btn_lr in the same cycle -> PAUSE, no lap_press. Toggle mode_down mid-run -> cnt_dir unchanged. rst mid-RUN -> IDLE, all outputs at reset values.
